// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared function codes, FSM state type and decode helpers for the mul/div unit
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_t;

    // Codes that start a multi-cycle operation
    function automatic logic is_muldiv_op(input logic [5:0] fn);
        return (fn == FUNCT_MULT) || (fn == FUNCT_MULTU) ||
               (fn == FUNCT_DIV)  || (fn == FUNCT_DIVU);
    endfunction

    // Every code this unit owns; these must wait while an operation is in flight
    function automatic logic is_unit_op(input logic [5:0] fn);
        return is_muldiv_op(fn) ||
               (fn == FUNCT_MFHI) || (fn == FUNCT_MTHI) ||
               (fn == FUNCT_MFLO) || (fn == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add / restoring-divide datapath over {rem, acc}
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] rem;
    logic [W-1:0] acc;
    logic [W-1:0] opb;
    logic [W-1:0] rem_next;
    logic [W-1:0] acc_next;
    logic [W:0]   add_sum;
    logic [W:0]   shifted;
    logic         fits;
    logic [W-1:0] diff;

    assign add_sum = {1'b0, rem} + {1'b0, opb};
    assign shifted = {rem, acc[W-1]};
    assign fits    = shifted >= {1'b0, opb};
    // When the divisor fits, the difference is below the divisor so W bits hold it exactly
    assign diff    = shifted[W-1:0] - opb;

    // Single iteration: multiply shifts the running product right, divide shifts the dividend left
    always_comb begin
        rem_next = rem;
        acc_next = acc;
        if (is_div) begin
            if (fits) begin
                rem_next = diff;
                acc_next = {acc[W-2:0], 1'b1};
            end else begin
                rem_next = shifted[W-1:0];
                acc_next = {acc[W-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                rem_next = add_sum[W:1];
                acc_next = {add_sum[0], acc[W-1:1]};
            end else begin
                rem_next = {1'b0, rem[W-1:1]};
                acc_next = {rem[0], acc[W-1:1]};
            end
        end
    end

    // Working registers: load operands on accept, advance one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
            acc <= '0;
            opb <= '0;
        end else if (load) begin
            rem <= '0;
            acc <= a_in;
            opb <= b_in;
        end else if (step) begin
            rem <= rem_next;
            acc <= acc_next;
        end
    end

    assign rem_o = rem;
    assign acc_o = acc;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - mul/div sequencer with sign fix-up, HI/LO ownership and pipeline stall
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [5:0]            fncode_i,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] mf_data_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(DATA_WIDTH);

    muldiv_state_t         state;
    muldiv_state_t         state_next;
    logic [CW-1:0]         count;
    logic                  is_div;
    logic                  neg_q;
    logic                  neg_r;
    logic                  b_zero;
    logic [DATA_WIDTH-1:0] a_raw;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    logic                  accept;
    logic                  signed_op;
    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0] quo_fix;
    logic [DATA_WIDTH-1:0] rem_fix;
    logic                  idle_valid;

    assign busy_o     = (state != IDLE);
    assign idle_valid = valid_i && !busy_o;
    assign accept     = idle_valid && is_muldiv_op(fncode_i);
    assign stall_o    = valid_i && busy_o && is_unit_op(fncode_i);

    assign signed_op = (fncode_i == FUNCT_MULT) || (fncode_i == FUNCT_DIV);
    assign sign_a    = signed_op && op_a_i[DATA_WIDTH-1];
    assign sign_b    = signed_op && op_b_i[DATA_WIDTH-1];
    assign a_mag     = sign_a ? -op_a_i : op_a_i;
    assign b_mag     = sign_b ? -op_b_i : op_b_i;

    muldiv_iter #(.W(DATA_WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (state == RUN),
        .is_div (is_div),
        .a_in   (a_mag),
        .b_in   (b_mag),
        .rem_o  (rem),
        .acc_o  (acc)
    );

    assign prod     = {rem, acc};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -acc : acc;
    assign rem_fix  = neg_r ? -rem : rem;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: accept in IDLE, run DATA_WIDTH iterations, one fix-up cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (count == CW'(DATA_WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Iteration counter and per-operation flags latched at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= '0;
        end else if (accept) begin
            count  <= '0;
            is_div <= (fncode_i == FUNCT_DIV) || (fncode_i == FUNCT_DIVU);
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            b_zero <= (op_b_i == '0);
            a_raw  <= op_a_i;
        end else if (state == RUN) begin
            count  <= count + 1'b1;
        end
    end

    // HI/LO commit: result at FIX, or direct moves when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (!is_div) begin
                {hi, lo} <= prod_fix;
            end else if (b_zero) begin
                hi <= a_raw;
                lo <= '1;
            end else begin
                hi <= rem_fix;
                lo <= quo_fix;
            end
        end else if (idle_valid && fncode_i == FUNCT_MTHI) begin
            hi <= op_a_i;
        end else if (idle_valid && fncode_i == FUNCT_MTLO) begin
            lo <= op_a_i;
        end
    end

    // Move-from read port: committed register only while idle
    always_comb begin
        mf_data_o = '0;
        if (idle_valid && fncode_i == FUNCT_MFHI) mf_data_o = hi;
        if (idle_valid && fncode_i == FUNCT_MFLO) mf_data_o = lo;
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [5:0]  fncode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        busy;
    logic [31:0] mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    muldiv_ctrl #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid),
        .fncode_i  (fncode),
        .op_a_i    (op_a),
        .op_b_i    (op_b),
        .stall_o   (stall),
        .busy_o    (busy),
        .mf_data_o (mf_data),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge; outputs are sampled #1 later
    task automatic drive(input logic v, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid  = v;
        fncode = fn;
        op_a   = a;
        op_b   = b;
        #1;
    endtask

    // Issue an op, then idle until busy drops; returns the number of busy cycles seen
    task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b, output int nbusy);
        drive(1'b1, fn, a, b);
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 6'h00, 32'h0, 32'h0);
            if (!busy) break;
            nbusy++;
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || stall !== 1'b0 || mf_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b stall=%b mf=%h, need all zero", hi, lo, busy, stall, mf_data);
        end
    endtask

    task automatic test_reset_midop;
        drive(1'b1, F_MTHI, 32'hAAAA5555, 32'h0);
        drive(1'b1, F_MTLO, 32'h5555AAAA, 32'h0);
        drive(1'b1, F_MULT, 32'h00000003, 32'h00000005);
        for (int c = 1; c < 10; c++) drive(1'b0, 6'h00, 32'h0, 32'h0);
        n_checks++;
        if (busy !== 1'b1 || hi !== 32'hAAAA5555 || lo !== 32'h5555AAAA) begin
            n_fail++;
            $display("FAIL midop_before_reset: busy=%b hi=%h lo=%h, need 1 aaaa5555 5555aaaa", busy, hi, lo);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL midop_reset_async: busy=%b hi=%h lo=%h, need 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, F_MFLO, 32'h0, 32'h0);
        n_checks++;
        if (mf_data !== 32'h0 || stall !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_mflo_after: mf=%h stall=%b busy=%b, need 0 0 0", mf_data, stall, busy);
        end
        drive(1'b0, 6'h00, 32'h0, 32'h0);
        n_checks++;
        if (busy !== 1'b0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL midop_stays_idle: busy=%b lo=%h, need 0 0", busy, lo);
        end
    endtask

    task automatic test_mult_stall;
        int bad;
        bad = 0;
        drive(1'b1, F_MULT, 32'hFFFFFFFE, 32'h00000003);
        for (int c = 1; c <= 33; c++) begin
            drive(1'b1, F_MFLO, 32'h0, 32'h0);
            if (stall !== 1'b1 || mf_data !== 32'h0 || lo !== 32'h0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mult_stall_window: %0d bad cycles in 1..33, need 0 (stall=1, mf=0, lo unchanged)", bad);
        end
        drive(1'b1, F_MFLO, 32'h0, 32'h0);
        n_checks++;
        if (stall !== 1'b0 || mf_data !== 32'hFFFFFFFA) begin
            n_fail++;
            $display("FAIL mult_mflo: stall=%b mf=%h, need 0 fffffffa", stall, mf_data);
        end
        drive(1'b1, F_MFHI, 32'h0, 32'h0);
        n_checks++;
        if (mf_data !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL mult_mfhi: mf=%h, need ffffffff", mf_data);
        end
    endtask

    task automatic test_multu;
        int nb;
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
        n_checks++;
        if (nb != 33) begin
            n_fail++;
            $display("FAIL multu_busy_cycles: got %0d, need 33", nb);
        end
        n_checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            n_fail++;
            $display("FAIL multu_result: hi=%h lo=%h, need fffffffe 00000001", hi, lo);
        end
    endtask

    task automatic test_divide;
        int nb;
        run_op(F_DIV, 32'hFFFFFFF9, 32'h00000002, nb);
        n_checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || nb != 33) begin
            n_fail++;
            $display("FAIL div_neg7_2: hi=%h lo=%h busy=%0d, need ffffffff fffffffd 33", hi, lo, nb);
        end
        run_op(F_DIVU, 32'h00000007, 32'h00000002, nb);
        n_checks++;
        if (hi !== 32'h00000001 || lo !== 32'h00000003) begin
            n_fail++;
            $display("FAIL divu_7_2: hi=%h lo=%h, need 00000001 00000003", hi, lo);
        end
        run_op(F_DIV, 32'h00000064, 32'hFFFFFFF9, nb);
        n_checks++;
        if (hi !== 32'h00000002 || lo !== 32'hFFFFFFF2) begin
            n_fail++;
            $display("FAIL div_100_neg7: hi=%h lo=%h, need 00000002 fffffff2", hi, lo);
        end
    endtask

    task automatic test_div_corners;
        int nb;
        run_op(F_DIVU, 32'h00000005, 32'h00000000, nb);
        n_checks++;
        if (hi !== 32'h00000005 || lo !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL divu_by_zero: hi=%h lo=%h, need 00000005 ffffffff", hi, lo);
        end
        run_op(F_DIV, 32'hFFFFFFF9, 32'h00000000, nb);
        n_checks++;
        if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL div_neg_by_zero: hi=%h lo=%h, need fffffff9 ffffffff", hi, lo);
        end
        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
        n_checks++;
        if (hi !== 32'h00000000 || lo !== 32'h80000000) begin
            n_fail++;
            $display("FAIL div_overflow: hi=%h lo=%h, need 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_move;
        drive(1'b1, F_MTHI, 32'h00001234, 32'h0);
        n_checks++;
        if (stall !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_no_stall: stall=%b busy=%b, need 0 0", stall, busy);
        end
        drive(1'b1, F_MFHI, 32'h0, 32'h0);
        n_checks++;
        if (mf_data !== 32'h00001234 || stall !== 1'b0 || hi !== 32'h00001234) begin
            n_fail++;
            $display("FAIL mfhi_after_mthi: mf=%h stall=%b hi=%h, need 00001234 0 00001234", mf_data, stall, hi);
        end
        drive(1'b1, F_MTLO, 32'hCAFEF00D, 32'h0);
        drive(1'b1, F_MFLO, 32'h0, 32'h0);
        n_checks++;
        if (mf_data !== 32'hCAFEF00D || hi !== 32'h00001234) begin
            n_fail++;
            $display("FAIL mflo_after_mtlo: mf=%h hi=%h, need cafef00d 00001234", mf_data, hi);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        int nb;
        bad = 0;
        drive(1'b1, F_MULT, 32'h00000006, 32'h00000007);
        for (int c = 1; c <= 33; c++) begin
            if (c == 5) begin
                drive(1'b1, 6'h20, 32'h0, 32'h0);
                n_checks++;
                if (stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL unknown_code_stall: stall=%b, need 0", stall);
                end
            end else begin
                drive(1'b1, F_DIV, 32'h00000064, 32'h00000007);
                if (stall !== 1'b1 || busy !== 1'b1) bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_stall_window: %0d bad cycles, need 0", bad);
        end
        drive(1'b1, F_DIV, 32'h00000064, 32'h00000007);
        n_checks++;
        if (stall !== 1'b0 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0000002A) begin
            n_fail++;
            $display("FAIL b2b_mult_result: stall=%b busy=%b hi=%h lo=%h, need 0 0 00000000 0000002a", stall, busy, hi, lo);
        end
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 6'h00, 32'h0, 32'h0);
            if (!busy) break;
            nb++;
        end
        n_checks++;
        if (nb != 33 || hi !== 32'h00000002 || lo !== 32'h0000000E) begin
            n_fail++;
            $display("FAIL b2b_div_result: busy=%0d hi=%h lo=%h, need 33 00000002 0000000e", nb, hi, lo);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        valid    = 1'b0;
        fncode   = 6'h00;
        op_a     = 32'h0;
        op_b     = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_reset_midop;
        test_mult_stall;
        test_multu;
        test_divide;
        test_div_corners;
        test_move;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the multi-cycle multiply/divide resource, plus the HI/LO register pair it owns.
- Sits beside the single-cycle ALU in EX and is driven by the same function code the ALU control produces.
- Accepts MULT/MULTU/DIV/DIVU, iterates one bit per cycle, and applies sign fix-up before writing HI/LO.
- Services MFHI/MFLO/MTHI/MTLO and raises a pipeline stall while an operation is in flight.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; the iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  EX stage holds a valid instruction
- fncode_i  in  6  function code (R-type funct field)
- op_a_i  in  DATA_WIDTH  rs value (dividend/multiplicand; MTHI/MTLO source)
- op_b_i  in  DATA_WIDTH  rt value (divisor/multiplier)
- stall_o  out  1  hold the pipeline this cycle
- busy_o  out  1  operation in flight
- mf_data_o  out  DATA_WIDTH  MFHI/MFLO read data
- hi_o  out  DATA_WIDTH  HI register
- lo_o  out  DATA_WIDTH  LO register

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n). This is fixed.
- Reset: state=IDLE, HI=LO=0, count=0, busy_o=0, stall_o=0, mf_data_o=0.
- Reset mid-operation aborts immediately. Partial results are discarded.
- Recognised codes: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. Any other code is ignored (no effect, no stall).
- FSM IDLE -> RUN -> FIX -> IDLE:
  - IDLE: valid_i plus MULT/MULTU/DIV/DIVU is accepted at the clock edge. The block latches operand magnitudes (absolute value for signed ops) and the sign flags, sets count=0, and moves to RUN.
  - RUN: one iteration per cycle; count increments. At the edge where count==DATA_WIDTH-1 the state moves to FIX.
  - FIX: applies sign correction and writes HI/LO at the edge, then returns to IDLE.
- busy_o=1 in RUN and FIX: DATA_WIDTH+1 cycles after the accept edge.
- A back-to-back mult/div is accepted in the first IDLE cycle after FIX.
- Multiply: shift-add producing a 2*DATA_WIDTH product {HI,LO}.
  - Signed: negate the 64-bit product if the operand signs differ.
- Divide: restoring, unsigned on magnitudes. LO=quotient, HI=remainder.
  - Signed: negate the quotient if signs differ; the remainder takes the dividend's sign.
- Divide by zero (both signednesses): LO=all ones, HI=op_a_i as latched (raw, not the magnitude). No fix-up.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0. This is the natural result.
- stall_o = valid_i & busy_o & (fncode_i is any of the 8 recognised codes). It is combinational.
  - A stalled op has no side effect. Accepting it is the pipeline's retry on a later cycle.
- MTHI/MTLO when not busy: write op_a_i into HI/LO at the edge. Single cycle.
- MFHI/MFLO when not busy: mf_data_o = HI/LO combinationally in the same cycle. Otherwise mf_data_o=0.
- hi_o/lo_o show the committed registers only. Intermediate iteration state is never visible.
- valid_i with a mult/div while busy: not accepted, stall_o=1, the in-flight op continues undisturbed.

Decomposition:
- Shared package (alongside existing OPCODE_/FUNCT_ constants) adds:
  - FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO.
  - muldiv_state_t enum {IDLE, RUN, FIX}.
- Optional sub-module muldiv_iter holds the per-cycle iteration datapath: shift-add / restore step over a {rem, acc} register pair. muldiv_ctrl keeps the FSM, counter, sign handling and HI/LO.

Test Plan:
- Reset with an op in flight: MULT accepted, rst_n low at cycle 10 -> HI=LO=0 and busy_o=0 immediately. The next MFLO returns 0.
- MULT 0xFFFFFFFE x 3 at cycle 0, MFLO held from cycle 1 -> stall_o=1 in cycles 1..33. In cycle 34 mf_data_o=0xFFFFFFFA, and MFHI gives 0xFFFFFFFF.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- Division corner cases:
  - DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 then MFHI next cycle -> mf_data_o=0x1234, no stall.
- DIV issued during a busy MULT -> stalled and ignored. It is accepted the cycle after FIX, and the MULT result is intact.
